// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory checker: CSR field positions, test/address mode
// encodings, scheduler states and the address LFSR polynomial.
package rtl_settings_pkg;

    localparam int TEST_MODE_HI  = 15;
    localparam int TEST_MODE_LO  = 14;
    localparam int ADDR_MODE_BIT = 13;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        READ_ONLY       = 2'b00,
        WRITE_ONLY      = 2'b01,
        WRITE_AND_CHECK = 2'b10
    } test_mode_t;

    typedef enum logic {
        RUN_ADDR = 1'b0,
        RND_ADDR = 1'b1
    } addr_mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    // The unused encoding 2'b11 behaves as READ_ONLY.
    function automatic test_mode_t decode_test_mode(input logic [1:0] bits);
        case (bits)
            2'b01:   return WRITE_ONLY;
            2'b10:   return WRITE_AND_CHECK;
            default: return READ_ONLY;
        endcase
    endfunction

endpackage

// File: rtl/addr_lfsr.sv
// Galois LFSR used as the pseudo-random address source; loadable seed, step
// enable, current value and combinational next value.
module addr_lfsr
    import rtl_settings_pkg::*;
#(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(LFSR_POLY)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] value_o,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Each bit shifts down one place and picks up the feedback where a tap is set.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == WIDTH - 1) begin : g_top
            assign next_o[gi] = POLY[gi] & value_q[0];
        end else begin : g_mid
            assign next_o[gi] = value_q[gi+1] ^ (POLY[gi] & value_q[0]);
        end
    end

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = seed_i;
        end else if (step_i) begin
            value_d = next_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_q <= '1;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/trans_scheduler.sv
// Issues a programmed run of write/read requests to the transmitter and reports
// completion/error. Define TRANS_SCHED_RND_ADDR_EN to enable pseudo-random addressing.
module trans_scheduler
    import rtl_settings_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       test_param_i,
    input  logic [CNT_W-1:0]  trans_count_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] addr_step_i,
    input  logic              cmp_error_i,
    input  logic              trans_ready_i,
    input  logic              trans_busy_i,
    output logic              trans_valid_o,
    output logic [ADDR_W-1:0] trans_addr_o,
    output logic              trans_type_o,
    output logic              test_done_o,
    output logic              test_error_o,
    output logic [CNT_W-1:0]  addr_done_o
);

    sched_state_t      state_q, state_d;
    test_mode_t        mode_q, mode_d;
    addr_mode_t        amode_q, amode_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              type_q, type_d;
    logic              phase_q, phase_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  addr_done_q, addr_done_d;

    test_mode_t        start_mode;
    addr_mode_t        start_amode;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              start_ok;
    logic              handshake;
    logic              completes;
    logic              last_addr;

    assign start_mode = decode_test_mode(test_param_i[TEST_MODE_HI:TEST_MODE_LO]);
    assign start_ok   = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign handshake  = valid_q && trans_ready_i;
    // In WRITE_AND_CHECK only the read (phase 1) finishes an address.
    assign completes  = handshake && (mode_q != WRITE_AND_CHECK || phase_q);
    assign last_addr  = completes && (addr_done_q + CNT_W'(1) == count_q);

`ifdef TRANS_SCHED_RND_ADDR_EN
    logic [ADDR_W-1:0] lfsr_value;
    logic [ADDR_W-1:0] lfsr_next;
    logic [ADDR_W-1:0] lfsr_seed;

    // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
    assign lfsr_seed   = (base_addr_i == '0) ? '1 : base_addr_i;
    assign start_amode = addr_mode_t'(test_param_i[ADDR_MODE_BIT]);
    assign start_addr  = (start_amode == RND_ADDR) ? lfsr_seed : base_addr_i;
    assign next_addr   = (amode_q == RND_ADDR) ? lfsr_next : addr_q + step_q;

    addr_lfsr #(
        .WIDTH (ADDR_W)
    ) u_addr_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (start_ok && start_amode == RND_ADDR),
        .seed_i  (lfsr_seed),
        .step_i  (completes && amode_q == RND_ADDR),
        .value_o (lfsr_value),
        .next_o  (lfsr_next)
    );
`else
    assign start_amode = RUN_ADDR;
    assign start_addr  = base_addr_i;
    assign next_addr   = addr_q + step_q;
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        amode_d     = amode_q;
        step_d      = step_q;
        count_d     = count_q;
        addr_d      = addr_q;
        type_d      = type_q;
        phase_d     = phase_q;
        valid_d     = valid_q;
        done_d      = done_q;
        error_d     = error_q;
        addr_done_d = addr_done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    mode_d      = start_mode;
                    amode_d     = start_amode;
                    step_d      = addr_step_i;
                    count_d     = trans_count_i;
                    addr_d      = start_addr;
                    type_d      = (start_mode == READ_ONLY);
                    phase_d     = 1'b0;
                    addr_done_d = '0;
                    error_d     = 1'b0;
                    if (trans_count_i == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                        done_d  = 1'b0;
                        valid_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    if (completes) begin
                        addr_done_d = addr_done_q + CNT_W'(1);
                        addr_d      = next_addr;
                        phase_d     = 1'b0;
                        type_d      = (mode_q == READ_ONLY);
                    end else begin
                        phase_d = 1'b1;
                        type_d  = 1'b1;
                    end
                end
                if (cmp_error_i) begin
                    error_d = 1'b1;
                end
                if (last_addr || cmp_error_i) begin
                    state_d = S_DRAIN;
                    valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                valid_d = 1'b0;
                if (cmp_error_i) begin
                    error_d = 1'b1;
                end
                if (!trans_busy_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mode_q      <= READ_ONLY;
            amode_q     <= RUN_ADDR;
            step_q      <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            type_q      <= 1'b0;
            phase_q     <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            addr_done_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            amode_q     <= amode_d;
            step_q      <= step_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            type_q      <= type_d;
            phase_q     <= phase_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
            addr_done_q <= addr_done_d;
        end
    end

    assign trans_valid_o = valid_q;
    assign trans_addr_o  = addr_q;
    assign trans_type_o  = type_q;
    assign test_done_o   = done_q;
    assign test_error_o  = error_q;
    assign addr_done_o   = addr_done_q;

endmodule

// File: doc/trans_scheduler.md
# trans_scheduler

Test-sequence controller that drives the transaction request port of the transmitter block: on a CSR start pulse it issues a programmed number of write/read requests over a valid/ready handshake, generates running or pseudo-random addresses, stops early on a compare error and reports completion once the transmitter has drained. It sits between the CSR block and the transmitter block in the memory checker.

## Interface
- ADDR_W, 32, transaction address width (matches transmitter trans_addr_i)
- CNT_W, 32, transaction counter width
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- start_i  in  1  single-cycle start pulse from CSR block
- test_param_i  in  32  CSR_TEST_PARAM word: [15:14] test_mode, [13] addr_mode (0 RUN, 1 RND)
- trans_count_i  in  CNT_W  number of addresses to test
- base_addr_i  in  ADDR_W  first address (RUN) / LFSR seed (RND)
- addr_step_i  in  ADDR_W  RUN-mode address increment
- cmp_error_i  in  1  compare error pulse
- trans_ready_i  in  1  transmitter ready
- trans_busy_i  in  1  transmitter busy
- trans_valid_o  out  1  request valid
- trans_addr_o  out  ADDR_W  request address
- trans_type_o  out  1  0 = write, 1 = read
- test_done_o  out  1  test finished, held until next start
- test_error_o  out  1  test stopped on compare error, held until next start
- addr_done_o  out  CNT_W  addresses completed so far

## Operation
- test_mode: 2'b00 READ_ONLY, 2'b01 WRITE_ONLY, 2'b10 WRITE_AND_CHECK, 2'b11 treated as READ_ONLY.
- WRITE_AND_CHECK: per address, one write then one read at the same address; an address counts as done after the read handshake.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + start_i: latch test_param_i, trans_count_i and addr_step_i; clear addr_done_o, test_done_o, test_error_o; load address; go to ISSUE. If trans_count_i == 0, go to DONE directly with test_done_o = 1 and no requests.
- ISSUE: trans_valid_o = 1. Address and type are held stable until (trans_valid_o && trans_ready_i). On handshake, advance phase/address. If the last address completes, go to DRAIN.
- RUN address: next = current + addr_step_i, modulo 2^ADDR_W (wrap silently).
- RND address: next = LFSR step. Seed = base_addr_i, with all-zero replaced by all-ones.
- cmp_error_i in ISSUE or DRAIN: set test_error_o, go or stay in DRAIN. A handshake in the same cycle still increments addr_done_o.
- DRAIN: trans_valid_o = 0. On !trans_busy_i, go to DONE and set test_done_o.
- start_i in ISSUE or DRAIN is ignored.
- Reset values: state IDLE; all outputs 0; LFSR all-ones.

## Timing
- All outputs are registered. trans_valid_o has no combinational path from trans_ready_i.
- start_i sampled at edge 0: trans_valid_o = 1 with the first address after edge 0 (one-cycle latency).
- Handshake at edge n: the next address/type is visible after edge n, with valid kept high (back-to-back, one request per cycle when ready stays high).
- cmp_error_i sampled at edge t: trans_valid_o = 0 and test_error_o = 1 after edge t.
- trans_busy_i low sampled at edge d in DRAIN: test_done_o = 1 after edge d.
- Last handshake at edge n: earliest test_done_o after edge n+1.

## Configuration
- TRANS_SCHED_RND_ADDR_EN defined: addr_lfsr is instantiated and addr_mode = 1 selects pseudo-random addresses.
- Undefined: the LFSR is absent, addr_mode is ignored and addressing is always RUN.

## Structure
- rtl_settings_pkg gains:
  - test_mode_t (READ_ONLY, WRITE_ONLY, WRITE_AND_CHECK)
  - addr_mode_t (RUN_ADDR, RND_ADDR)
  - sched_state_t
  - CSR field bit indices
  - LFSR_POLY constant (32-bit Galois, x^32+x^22+x^2+x+1)
- One sub-module, addr_lfsr: Galois LFSR of width ADDR_W with load/seed, step-enable and value output.

## Test plan
- WRITE_ONLY, RUN, base 0x100, step 4, count 3, ready always 1 -> writes to 0x100, 0x104, 0x108 on consecutive cycles; addr_done_o = 3; test_done_o after busy falls.
- WRITE_AND_CHECK, RUN, base 0x0, step 1, count 2 -> sequence W0, R0, W1, R1; trans_addr_o held while ready = 0 for 3 cycles.
- RUN, base 0xFFFFFFFE, step 1, count 3 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- cmp_error_i pulse after the 2nd of 5 addresses -> valid drops the next cycle; test_error_o = 1; addr_done_o = 2; done after busy clears; a new start clears the flags.
- trans_count_i = 0 -> no valid, test_done_o = 1 one cycle after start. Also: rst_i asserted mid-ISSUE -> all outputs 0 immediately, state IDLE.
- RND (macro defined), seed 0 -> first address 0xFFFFFFFF, then LFSR sequence matching the reference model; macro undefined -> RUN sequence.
